ofdm_rx_sequencer: RTL and testbench
====================================

// Module: ofdm_rx_sequencer
// PURPOSE
//  Frame-level controller between the short/long sync chain and the FFT/equaliser chain.
//  After short-preamble detection it waits for the long-preamble peak and windows two LTS symbols into the FFT.
//  It then strips the 16-sample CP from each data symbol and forwards 64 samples per symbol.
//  After N_SYM symbols, or on timeout, it ends the frame and pulses a sync-chain reset.
// PARAMETERS
//  N_FFT        64   samples forwarded per LTS/data symbol
//  N_CP         16   cyclic-prefix samples discarded before each data symbol
//  N_SYM        4    data symbols per frame
//  LTS_TIMEOUT  256  in_strobe count in WAIT_LTS before abort
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous, active-low reset
//  enable       in   1  0 = synchronous return to IDLE
//  in_strobe    in   1  one input sample valid this cycle
//  stf_det      in   1  short preamble detected (level or pulse)
//  lts_peak     in   1  coincident with in_strobe of LTS1 sample 0
//  fft_ready    in   1  FFT can accept a sample
//  fft_di_en    out  1  forward this sample to FFT (registered)
//  fft_lts      out  1  forwarded sample belongs to LTS1/LTS2
//  fft_last     out  1  last (64th) sample of a symbol
//  sym_idx      out  3  data-symbol index 0..N_SYM-1 (0 during LTS)
//  samp_idx     out  6  sample index within current 64-window
//  frame_done   out  1  1-cycle pulse with last sample of last symbol
//  sync_rst_n   out  1  1-cycle low pulse to reset sync chain
//  busy         out  1  state != IDLE
//  err_timeout  out  1  sticky: LTS not found
//  err_overflow out  1  sticky: sample arrived while fft_ready=0
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0 except sync_rst_n=1; counters 0.
//  Counting: counters advance only on in_strobe; gaps between strobes are allowed.
//  Output timing: all outputs registered; fft_di_en/fft_lts/fft_last/idx appear 1 cycle after the qualifying in_strobe.
//  States:
//   IDLE: stf_det=1 -> WAIT_LTS; clear errors and timeout count. lts_peak is ignored here, even if it coincides with stf_det.
//   WAIT_LTS: count strobes.
//    - lts_peak & in_strobe -> LTS1; that sample is forwarded as samp_idx 0.
//    - Count reaches LTS_TIMEOUT with no peak -> err_timeout=1, sync_rst_n low 1 cycle, IDLE.
//    - If peak and timeout land on the same strobe, the peak wins.
//   LTS1 -> LTS2: each runs N_FFT strobes with fft_lts=1; fft_last on samp_idx 63.
//   LTS2 -> DATA_CP.
//   DATA_CP: N_CP strobes, none forwarded -> DATA_SYM.
//   DATA_SYM: N_FFT strobes forwarded; fft_last on the 64th.
//    - If sym_idx < N_SYM-1: sym_idx++, go to DATA_CP.
//    - Otherwise: frame_done with that sample, sync_rst_n low the next cycle, IDLE.
//  Overflow: in_strobe inside LTS1/LTS2/DATA_SYM with fft_ready=0 sets err_overflow.
//   The sample is not forwarded (no fft_di_en) but is still counted, so symbol framing is kept.
//  stf_det and lts_peak outside the states above are ignored.
//  enable=0: next cycle IDLE, counters 0, no frame_done, no sync_rst_n pulse; error flags hold.
//  Errors are sticky until rst_n or the next accepted stf_det.
//  Counter widths: samp counter wraps 63->0 only via state change, never free-running.
// TESTING
//  T1 nominal: stf_det, 10 strobes, lts_peak, then 128+4*80 strobes.
//     -> 128 fft_di_en with fft_lts=1; fft_last at LTS samples 64 and 128.
//     -> per data symbol: 16 skipped, 64 forwarded, sym_idx 0..3.
//     -> single frame_done on the last sample; sync_rst_n low 1 cycle after; busy=0.
//  T2 timeout: stf_det, then 256 strobes with no peak.
//     -> err_timeout=1 and sync_rst_n pulse 1 cycle after the 256th strobe; IDLE.
//     -> peak on strobe 256 instead -> enters LTS1, no error.
//  T3 overflow: fft_ready=0 for 3 strobes in symbol 2, samp 10-12.
//     -> err_overflow=1; those 3 not forwarded; symbol 2 still ends after 80 strobes.
//  T4 async reset at symbol 1, samp_idx 30.
//     -> outputs 0 and sync_rst_n=1 immediately; next stf_det starts a clean frame.
//  T5 enable=0 mid-LTS2 -> IDLE next cycle; no frame_done, no sync_rst_n pulse.
//  T6 strobes gapped 1-in-4 cycles, with stf_det and lts_peak in the same IDLE cycle.
//     -> peak ignored (stays WAIT_LTS); a later peak gives counts identical to T1.

Source files
------------

// File: rtl/ofdm_rx_sequencer.sv
// Frame sequencer between the sync chain and the FFT/equaliser: windows two LTS
// symbols, strips the CP from each data symbol and closes the frame.
module ofdm_rx_sequencer #(
    parameter int N_FFT       = 64,
    parameter int N_CP        = 16,
    parameter int N_SYM       = 4,
    parameter int LTS_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       in_strobe,
    input  logic       stf_det,
    input  logic       lts_peak,
    input  logic       fft_ready,
    output logic       fft_di_en,
    output logic       fft_lts,
    output logic       fft_last,
    output logic [2:0] sym_idx,
    output logic [5:0] samp_idx,
    output logic       frame_done,
    output logic       sync_rst_n,
    output logic       busy,
    output logic       err_timeout,
    output logic       err_overflow
);

    localparam int TW = $clog2(LTS_TIMEOUT + 1);
    localparam logic [5:0]    SAMP_LAST = 6'(N_FFT - 1);
    localparam logic [5:0]    CP_LAST   = 6'(N_CP - 1);
    localparam logic [2:0]    SYM_LAST  = 3'(N_SYM - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LTS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_LTS, LTS1, LTS2, DATA_CP, DATA_SYM
    } state_t;

    state_t        state, state_d;
    logic [5:0]    samp_cnt, samp_d;
    logic [2:0]    sym_cnt, sym_d;
    logic [TW-1:0] tmo_cnt, tmo_d;
    logic          rst_pend, rst_pend_d;
    logic          di_d, lts_d, last_d, fd_d, sync_d, eto_d, eov_d;
    logic [5:0]    sidx_d;
    logic [2:0]    yidx_d;
    logic          win, win_lts;

    always_comb begin
        state_d    = state;
        samp_d     = samp_cnt;
        sym_d      = sym_cnt;
        tmo_d      = tmo_cnt;
        rst_pend_d = 1'b0;
        di_d       = 1'b0;
        lts_d      = 1'b0;
        last_d     = 1'b0;
        fd_d       = 1'b0;
        sidx_d     = samp_idx;
        yidx_d     = sym_idx;
        sync_d     = ~rst_pend;
        eto_d      = err_timeout;
        eov_d      = err_overflow;
        win        = 1'b0;
        win_lts    = 1'b0;

        case (state)
            IDLE: begin
                if (stf_det) begin
                    state_d = WAIT_LTS;
                    tmo_d   = '0;
                    samp_d  = '0;
                    sym_d   = '0;
                    eto_d   = 1'b0;
                    eov_d   = 1'b0;
                end
            end
            WAIT_LTS: begin
                if (in_strobe) begin
                    // a peak on the timeout strobe still starts the frame
                    if (lts_peak) begin
                        win     = 1'b1;
                        win_lts = 1'b1;
                        samp_d  = 6'd1;
                        state_d = LTS1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        eto_d   = 1'b1;
                        sync_d  = 1'b0;
                        tmo_d   = '0;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_cnt + 1'b1;
                    end
                end
            end
            LTS1, LTS2: begin
                if (in_strobe) begin
                    win     = 1'b1;
                    win_lts = 1'b1;
                    if (samp_cnt == SAMP_LAST) begin
                        samp_d  = '0;
                        state_d = (state == LTS1) ? LTS2 : DATA_CP;
                    end else begin
                        samp_d = samp_cnt + 6'd1;
                    end
                end
            end
            DATA_CP: begin
                if (in_strobe) begin
                    if (samp_cnt == CP_LAST) begin
                        samp_d  = '0;
                        state_d = DATA_SYM;
                    end else begin
                        samp_d = samp_cnt + 6'd1;
                    end
                end
            end
            DATA_SYM: begin
                if (in_strobe) begin
                    win = 1'b1;
                    if (samp_cnt == SAMP_LAST) begin
                        samp_d = '0;
                        if (sym_cnt == SYM_LAST) begin
                            fd_d       = 1'b1;
                            rst_pend_d = 1'b1;
                            sym_d      = '0;
                            state_d    = IDLE;
                        end else begin
                            sym_d   = sym_cnt + 3'd1;
                            state_d = DATA_CP;
                        end
                    end else begin
                        samp_d = samp_cnt + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // a starved sample is still counted so the symbol grid is kept
        if (win) begin
            sidx_d = samp_cnt;
            yidx_d = win_lts ? 3'd0 : sym_cnt;
            di_d   = fft_ready;
            lts_d  = win_lts & fft_ready;
            last_d = (samp_cnt == SAMP_LAST) & fft_ready;
            if (!fft_ready) eov_d = 1'b1;
        end

        if (!enable) begin
            state_d    = IDLE;
            samp_d     = '0;
            sym_d      = '0;
            tmo_d      = '0;
            rst_pend_d = 1'b0;
            di_d       = 1'b0;
            lts_d      = 1'b0;
            last_d     = 1'b0;
            fd_d       = 1'b0;
            sidx_d     = '0;
            yidx_d     = '0;
            sync_d     = 1'b1;
            eto_d      = err_timeout;
            eov_d      = err_overflow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            samp_cnt     <= '0;
            sym_cnt      <= '0;
            tmo_cnt      <= '0;
            rst_pend     <= 1'b0;
            fft_di_en    <= 1'b0;
            fft_lts      <= 1'b0;
            fft_last     <= 1'b0;
            frame_done   <= 1'b0;
            samp_idx     <= '0;
            sym_idx      <= '0;
            sync_rst_n   <= 1'b1;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_d;
            samp_cnt     <= samp_d;
            sym_cnt      <= sym_d;
            tmo_cnt      <= tmo_d;
            rst_pend     <= rst_pend_d;
            fft_di_en    <= di_d;
            fft_lts      <= lts_d;
            fft_last     <= last_d;
            frame_done   <= fd_d;
            samp_idx     <= sidx_d;
            sym_idx      <= yidx_d;
            sync_rst_n   <= sync_d;
            err_timeout  <= eto_d;
            err_overflow <= eov_d;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ofdm_rx_sequencer.sv
// Scoreboard bench for ofdm_rx_sequencer: a sample-position model predicts each
// forwarded sample; a negedge monitor pops and compares.
module tb_ofdm_rx_sequencer;

    localparam int NF = 64, NC = 16, NS = 4, TMO = 256;
    localparam int FRAME = 2 * NF + NS * (NC + NF);

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1;
    logic in_strobe = 1'b0, stf_det = 1'b0, lts_peak = 1'b0, fft_ready = 1'b1;
    logic fft_di_en, fft_lts, fft_last, frame_done, sync_rst_n, busy;
    logic err_timeout, err_overflow;
    logic [2:0] sym_idx;
    logic [5:0] samp_idx;

    ofdm_rx_sequencer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_strobe(in_strobe),
        .stf_det(stf_det), .lts_peak(lts_peak), .fft_ready(fft_ready),
        .fft_di_en(fft_di_en), .fft_lts(fft_lts), .fft_last(fft_last),
        .sym_idx(sym_idx), .samp_idx(samp_idx), .frame_done(frame_done),
        .sync_rst_n(sync_rst_n), .busy(busy), .err_timeout(err_timeout),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] s;
        logic [2:0] y;
        logic       lts;
        logic       last;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int vectors = 0, miscompares = 0;
    int fwd_cnt = 0, sync_lows = 0;
    int m_phase = 0, m_wcnt = 0, m_k = 0, m_push = 0, m_sync_exp = 0;
    logic m_err_to = 1'b0, m_err_ov = 1'b0, en = 1'b1;
    logic prev_fd = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // position k counts strobes from the LTS peak (k=0 is LTS1 sample 0)
    task automatic frame_sample(input logic rdy);
        exp_t e;
        int j, off;
        logic w;
        e = '0;
        w = 1'b0;
        if (m_k < 2 * NF) begin
            w = 1'b1; e.lts = 1'b1; e.s = 6'(m_k % NF); e.y = 3'd0;
        end else begin
            j = m_k - 2 * NF;
            off = j % (NC + NF);
            if (off >= NC) begin
                w = 1'b1; e.s = 6'(off - NC); e.y = 3'(j / (NC + NF));
            end
        end
        e.last = w && (e.s == 6'(NF - 1));
        e.fd   = (m_k == FRAME - 1);
        if (w && !rdy) m_err_ov = 1'b1;
        if (w && rdy) begin q.push_back(e); m_push++; end
        if (m_k == FRAME - 1) begin m_phase = 0; m_sync_exp++; end
        m_k++;
    endtask

    task automatic model_step(input logic st, stf, pk, rdy);
        if (!en) m_phase = 0;
        else if (m_phase == 0) begin
            if (stf) begin m_phase = 1; m_wcnt = 0; m_err_to = 1'b0; m_err_ov = 1'b0; end
        end else if (m_phase == 1) begin
            if (st) begin
                if (pk) begin m_phase = 2; m_k = 0; frame_sample(rdy); end
                else begin
                    m_wcnt++;
                    if (m_wcnt == TMO) begin m_err_to = 1'b1; m_sync_exp++; m_phase = 0; end
                end
            end
        end else if (st) frame_sample(rdy);
    endtask

    task automatic cyc(input logic st, stf, pk, rdy);
        @(negedge clk);
        in_strobe = st; stf_det = stf; lts_peak = pk; fft_ready = rdy; enable = en;
        model_step(st, stf, pk, rdy);
    endtask

    task automatic gaps(input int gfix, input int grnd);
        repeat (gfix + $urandom_range(grnd, 0)) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_frame(input int pre, gfix, grnd, drop_pct, dlo, dhi, input logic first_pk);
        logic rdy;
        cyc(first_pk, 1'b1, first_pk, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("busy_after_stf", busy, 1);
        for (int i = 0; i < pre; i++) begin cyc(1'b1, 1'b0, 1'b0, 1'b1); gaps(gfix, grnd); end
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        gaps(gfix, grnd);
        for (int k = 1; k < FRAME; k++) begin
            rdy = !(k >= dlo && k <= dhi);
            if (drop_pct > 0 && k != FRAME - 1 && $urandom_range(99, 0) < drop_pct) rdy = 1'b0;
            cyc(1'b1, 1'b0, 1'b0, rdy);
            gaps(gfix, grnd);
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic post_chk(input string nm);
        chk({nm, "_queue_drained"}, q.size(), 0);
        chk({nm, "_fwd_total"}, fwd_cnt, m_push);
        chk({nm, "_sync_pulses"}, sync_lows, m_sync_exp);
        chk({nm, "_err_timeout"}, err_timeout, m_err_to);
        chk({nm, "_err_overflow"}, err_overflow, m_err_ov);
        chk({nm, "_busy"}, busy, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_fd) chk("sync_after_frame_done", sync_rst_n, 0);
            if (!sync_rst_n) sync_lows++;
            if (frame_done && !fft_di_en) chk("frame_done_without_sample", 0, 1);
            if (fft_di_en) begin
                fwd_cnt++;
                if (q.size() == 0) chk("unexpected_forward", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sample", {samp_idx, sym_idx, fft_lts, fft_last, frame_done}, e);
                end
            end
            prev_fd = frame_done;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        #23;
        chk("rst_di_en", fft_di_en, 0);
        chk("rst_sync", sync_rst_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {fft_lts, fft_last, frame_done, err_timeout, err_overflow}, 0);
        chk("rst_idx", {sym_idx, samp_idx}, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // nominal frame
        f0 = fwd_cnt;
        run_frame(10, 0, 0, 0, -1, -1, 1'b0);
        chk("t1_fwd_384", fwd_cnt - f0, 384);
        post_chk("t1");

        // timeout on the 256th strobe
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < TMO; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_err_timeout", err_timeout, 1);
        chk("t2_sync_low", sync_rst_n, 0);
        chk("t2_idle", busy, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_sync_release", sync_rst_n, 1);
        post_chk("t2a");
        // peak on strobe 256 wins over the timeout
        run_frame(TMO - 1, 0, 0, 0, -1, -1, 1'b0);
        post_chk("t2b");

        // overflow at symbol 2, samples 10..12
        f0 = fwd_cnt;
        run_frame(3, 0, 1, 0, 2 * NF + 2 * (NC + NF) + NC + 10, 2 * NF + 2 * (NC + NF) + NC + 12, 1'b0);
        chk("t3_fwd_381", fwd_cnt - f0, 381);
        chk("t3_overflow", err_overflow, 1);
        post_chk("t3");

        // async reset at symbol 1, samp 30
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 2 * NF + (NC + NF) + NC + 30; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_strobe = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t4_di_en", fft_di_en, 0);
        chk("t4_busy", busy, 0);
        chk("t4_sync", sync_rst_n, 1);
        chk("t4_idx", {sym_idx, samp_idx, fft_lts, fft_last}, 0);
        m_push = m_push - q.size();
        q.delete();
        m_phase = 0; m_err_to = 1'b0; m_err_ov = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_frame(7, 0, 1, 0, -1, -1, 1'b0);
        post_chk("t4");

        // enable drop mid-LTS2
        f0 = fwd_cnt;
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= NF + 20; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        en = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_idle", busy, 0);
        for (int i = 0; i < FRAME; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_fwd_85", fwd_cnt - f0, NF + 21);
        post_chk("t5");

        // 1-in-4 strobes, stf_det with a coincident (ignored) peak
        f0 = fwd_cnt;
        run_frame(10, 3, 0, 0, -1, -1, 1'b1);
        chk("t6_fwd_384", fwd_cnt - f0, 384);
        post_chk("t6");

        // randomized frames
        for (int n = 0; n < 4; n++) begin
            run_frame($urandom_range(200, 0), 0, 2, 3, -1, -1, 1'b0);
            post_chk("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
